// File: rtl/exec_if.sv
// Bundled instruction, register-file, ALU and CPDR signals of the execute datapath.
interface exec_if #(
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr0;
  logic [31:0]       instr1;
  logic [5:0]        ireg_r0;
  logic [5:0]        ireg_r1;
  logic [DATA_W-1:0] ireg_d0;
  logic [DATA_W-1:0] ireg_d1;
  logic [5:0]        ireg_rw;
  logic [DATA_W-1:0] ireg_dw;
  logic              ireg_we;
  logic [DATA_W-1:0] alu_d0;
  logic [DATA_W-1:0] alu_d1;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_dout;
  logic              cpdr_valid;
  logic              cpdr_ready;
  logic [DATA_W-1:0] cpdr_data;
  logic              illegal_op;

  // datapath side
  modport master (
    input  instr_valid, instr0, instr1, ireg_d0, ireg_d1, alu_dout, cpdr_ready,
    output instr_ready, ireg_r0, ireg_r1, ireg_rw, ireg_dw, ireg_we,
           alu_d0, alu_d1, alu_op, cpdr_valid, cpdr_data, illegal_op
  );

  // decoder / register file / ALU / CPDR consumer side
  modport slave (
    output instr_valid, instr0, instr1, ireg_d0, ireg_d1, alu_dout, cpdr_ready,
    input  instr_ready, ireg_r0, ireg_r1, ireg_rw, ireg_dw, ireg_we,
           alu_d0, alu_d1, alu_op, cpdr_valid, cpdr_data, illegal_op
  );
endinterface

// File: rtl/exec_datapath.sv
// Multi-cycle execute datapath: accept instruction, read registers, run ALU,
// write back or export a CPDR value.
//
// state  | meaning
// IDLE   | waiting for an instruction (instr_ready=1)
// READ   | register-file read of op1/op2, operands latched
// EXEC   | ALU operands driven, waiting ALU_LAT extra cycles
// WB     | single-cycle register write of op0
// CPDR   | holding cpdr_data until cpdr_ready
module exec_datapath #(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 0
) (
  input  logic   clk,
  input  logic   reset_n,
  exec_if.master bus
);
  localparam logic [7:0] OP_LIMM16 = 8'h02;
  localparam logic [7:0] OP_LIMM32 = 8'h03;
  localparam logic [7:0] OP_CP     = 8'h04;
  localparam logic [7:0] OP_CPDR   = 8'h05;
  localparam logic [7:0] OP_OR     = 8'h10;
  localparam logic [7:0] OP_XOR    = 8'h11;
  localparam logic [7:0] OP_AND    = 8'h12;
  localparam logic [7:0] OP_ADD    = 8'h14;
  localparam logic [7:0] OP_SUB    = 8'h15;
  localparam logic [7:0] OP_SHL    = 8'h18;
  localparam logic [7:0] OP_SAR    = 8'h19;

  localparam logic [1:0] LAT_LAST = 2'(ALU_LAT);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_CPDR} state_t;

  state_t            state_q, state_d;
  logic [31:6]       ir0_q;
  logic [DATA_W-1:0] a_q, b_q, r_q;
  logic [1:0]        cnt_q;
  logic              illegal_q;

  logic [7:0] op_in, op_q;
  logic       hs, in_legal, in_limm;

  assign op_in    = bus.instr0[31:24];
  assign op_q     = ir0_q[31:24];
  assign hs       = bus.instr_valid && (state_q == S_IDLE);
  assign in_limm  = (op_in == OP_LIMM16) || (op_in == OP_LIMM32);
  assign in_legal = op_in inside {OP_LIMM16, OP_LIMM32, OP_CP, OP_CPDR, OP_OR, OP_XOR,
                                  OP_AND, OP_ADD, OP_SUB, OP_SHL, OP_SAR};

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state decode and per-state output drive; everything idles at zero
  always_comb begin
    state_d         = state_q;
    bus.instr_ready = 1'b0;
    bus.ireg_r0     = '0;
    bus.ireg_r1     = '0;
    bus.ireg_rw     = '0;
    bus.ireg_dw     = '0;
    bus.ireg_we     = 1'b0;
    bus.alu_d0      = '0;
    bus.alu_d1      = '0;
    bus.alu_op      = '0;
    bus.cpdr_valid  = 1'b0;
    bus.cpdr_data   = '0;
    bus.illegal_op  = illegal_q;
    case (state_q)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (hs && in_legal) state_d = in_limm ? S_WB : S_READ;
      end
      S_READ: begin
        bus.ireg_r0 = ir0_q[17:12];
        // copies read a single operand; keep the second port quiet
        bus.ireg_r1 = (op_q == OP_CP || op_q == OP_CPDR) ? 6'd0 : ir0_q[11:6];
        if (op_q == OP_CP)        state_d = S_WB;
        else if (op_q == OP_CPDR) state_d = S_CPDR;
        else                      state_d = S_EXEC;
      end
      S_EXEC: begin
        bus.alu_d0 = a_q;
        bus.alu_d1 = b_q;
        bus.alu_op = ir0_q[27:24];
        if (cnt_q == LAT_LAST) state_d = S_WB;
      end
      S_WB: begin
        bus.ireg_we = 1'b1;
        bus.ireg_rw = ir0_q[23:18];
        bus.ireg_dw = r_q;
        state_d     = S_IDLE;
      end
      S_CPDR: begin
        bus.cpdr_valid = 1'b1;
        bus.cpdr_data  = r_q;
        if (bus.cpdr_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // instruction latch, operands, result (also the held CPDR value) and EXEC counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir0_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hs) begin
            ir0_q <= bus.instr0[31:6];
            if (op_in == OP_LIMM16)      r_q <= DATA_W'($signed(bus.instr0[15:0]));
            else if (op_in == OP_LIMM32) r_q <= DATA_W'(bus.instr1);
          end
        end
        S_READ: begin
          a_q   <= bus.ireg_d0;
          b_q   <= bus.ireg_d1;
          r_q   <= bus.ireg_d0;
          cnt_q <= '0;
        end
        S_EXEC: begin
          if (cnt_q == LAT_LAST) r_q   <= bus.alu_dout;
          else                   cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // sticky flag for unsupported opcodes; only reset clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              illegal_q <= 1'b0;
    else if (hs && !in_legal)  illegal_q <= 1'b1;
  end
endmodule

// File: tb/tb_exec_datapath.sv
// Directed plus randomized bench for exec_datapath with a register-file/ALU
// environment and an instruction-level reference model.
module tb_exec_datapath;
  localparam int DW  = 32;
  localparam int LAT = 2;

  localparam logic [7:0] OP_LIMM16 = 8'h02;
  localparam logic [7:0] OP_LIMM32 = 8'h03;
  localparam logic [7:0] OP_CP     = 8'h04;
  localparam logic [7:0] OP_CPDR   = 8'h05;
  localparam logic [7:0] OP_OR     = 8'h10;
  localparam logic [7:0] OP_XOR    = 8'h11;
  localparam logic [7:0] OP_AND    = 8'h12;
  localparam logic [7:0] OP_ADD    = 8'h14;
  localparam logic [7:0] OP_SUB    = 8'h15;
  localparam logic [7:0] OP_SHL    = 8'h18;
  localparam logic [7:0] OP_SAR    = 8'h19;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] rf  [64];
  logic [31:0] mdl [64];

  exec_if #(.DATA_W(DW)) bus ();

  exec_datapath #(.DATA_W(DW), .ALU_LAT(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // environment: combinational register file read and ALU
  function automatic logic [31:0] alu_fn(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      4'h0: return x | y;
      4'h1: return x ^ y;
      4'h2: return x & y;
      4'h4: return x + y;
      4'h5: return x - y;
      4'h8: return x << y[4:0];
      4'h9: return $unsigned($signed(x) >>> y[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  assign bus.ireg_d0  = rf[bus.ireg_r0];
  assign bus.ireg_d1  = rf[bus.ireg_r1];
  assign bus.alu_dout = alu_fn(bus.alu_op, bus.alu_d0, bus.alu_d1);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one cycle; commits a register write seen during the cycle
  task automatic step();
    logic w;
    logic [5:0] a;
    logic [31:0] d;
    @(negedge clk);
    w = bus.ireg_we;
    a = bus.ireg_rw;
    d = bus.ireg_dw;
    @(posedge clk);
    if (w && reset_n) rf[a] = d;
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [5:0] d, input logic [5:0] s1, input logic [5:0] s2);
    return {op, d, s1, s2, 6'd0};
  endfunction

  function automatic logic [31:0] mk16(input logic [5:0] d, input logic [15:0] imm);
    return {OP_LIMM16, d, 2'b00, imm};
  endfunction

  // issue one instruction and check its whole lifetime against the model
  task automatic run_instr(input logic [31:0] i0, input logic [31:0] i1, input int hold);
    logic [7:0]  op;
    logic [5:0]  d, s1, s2;
    logic [31:0] a, b, expv;
    int          lat;
    bit          cp, ill;
    op = i0[31:24]; d = i0[23:18]; s1 = i0[17:12]; s2 = i0[11:6];
    a = mdl[s1]; b = mdl[s2];
    expv = 32'h0; lat = 0; cp = 1'b0; ill = 1'b0;
    case (op)
      OP_LIMM16: begin expv = {{16{i0[15]}}, i0[15:0]}; lat = 1; end
      OP_LIMM32: begin expv = i1; lat = 1; end
      OP_CP:     begin expv = a; lat = 2; end
      OP_CPDR:   begin expv = a; cp = 1'b1; end
      OP_OR:     begin expv = a | b; lat = 3 + LAT; end
      OP_XOR:    begin expv = a ^ b; lat = 3 + LAT; end
      OP_AND:    begin expv = a & b; lat = 3 + LAT; end
      OP_ADD:    begin expv = a + b; lat = 3 + LAT; end
      OP_SUB:    begin expv = a - b; lat = 3 + LAT; end
      OP_SHL:    begin expv = a << (b % 32); lat = 3 + LAT; end
      OP_SAR:    begin expv = $unsigned($signed(a) >>> (b % 32)); lat = 3 + LAT; end
      default:   ill = 1'b1;
    endcase
    chk("ready_before", 64'(bus.instr_ready), 64'(1));
    bus.instr_valid = 1'b1;
    bus.instr0 = i0;
    bus.instr1 = i1;
    if (cp && hold == 0) bus.cpdr_ready = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr0 = $urandom;
    bus.instr1 = $urandom;
    if (ill) begin
      chk("illegal_set", 64'(bus.illegal_op), 64'(1));
      chk("illegal_ready", 64'(bus.instr_ready), 64'(1));
      chk("illegal_we", 64'(bus.ireg_we), 64'(0));
    end else if (cp) begin
      chk("cpdr_n1_valid", 64'(bus.cpdr_valid), 64'(0));
      step();
      for (int k = 0; k < hold; k++) begin
        chk("cpdr_hold_valid", 64'(bus.cpdr_valid), 64'(1));
        chk("cpdr_hold_data", 64'(bus.cpdr_data), 64'(expv));
        chk("cpdr_hold_ready", 64'(bus.instr_ready), 64'(0));
        step();
      end
      bus.cpdr_ready = 1'b1;
      chk("cpdr_valid", 64'(bus.cpdr_valid), 64'(1));
      chk("cpdr_data", 64'(bus.cpdr_data), 64'(expv));
      chk("cpdr_we", 64'(bus.ireg_we), 64'(0));
      step();
      bus.cpdr_ready = 1'b0;
      chk("cpdr_done_valid", 64'(bus.cpdr_valid), 64'(0));
      chk("cpdr_done_ready", 64'(bus.instr_ready), 64'(1));
    end else begin
      int we_at = -1;
      int pulses = 0;
      logic [5:0] rw = 6'd0;
      logic [31:0] dw = 32'h0;
      for (int k = 1; k <= lat; k++) begin
        if (bus.ireg_we) begin
          pulses++; we_at = k; rw = bus.ireg_rw; dw = bus.ireg_dw;
        end
        chk("busy_ready", 64'(bus.instr_ready), 64'(0));
        step();
      end
      if (bus.ireg_we) pulses++;
      chk("we_cycle", 64'(we_at), 64'(lat));
      chk("we_pulses", 64'(pulses), 64'(1));
      chk("wr_addr", 64'(rw), 64'(d));
      chk("wr_data", 64'(dw), 64'(expv));
      chk("ready_after", 64'(bus.instr_ready), 64'(1));
      mdl[d] = expv;
    end
  endtask

  initial begin
    logic [7:0] ops [12];
    logic [31:0] i0;
    ops = '{OP_LIMM16, OP_LIMM32, OP_CP, OP_CPDR, OP_OR, OP_XOR, OP_AND,
            OP_ADD, OP_SUB, OP_SHL, OP_SAR, 8'hFF};
    for (int i = 0; i < 64; i++) begin
      rf[i] = $urandom;
      mdl[i] = rf[i];
    end
    bus.instr_valid = 1'b0;
    bus.instr0 = 32'h0;
    bus.instr1 = 32'h0;
    bus.cpdr_ready = 1'b0;
    step(); step();
    chk("rst_ready", 64'(bus.instr_ready), 64'(1));
    chk("rst_we", 64'(bus.ireg_we), 64'(0));
    chk("rst_cpdr_valid", 64'(bus.cpdr_valid), 64'(0));
    chk("rst_illegal", 64'(bus.illegal_op), 64'(0));
    chk("rst_alu_op", 64'(bus.alu_op), 64'(0));
    reset_n = 1'b1;
    step();

    run_instr(mk16(6'd5, 16'hFFFE), 32'h0, 0);
    chk("reg5", 64'(rf[5]), 64'(32'hFFFFFFFE));
    run_instr(mk(OP_LIMM32, 6'd3, 6'd0, 6'd0), 32'h12345678, 0);
    chk("reg3", 64'(rf[3]), 64'(32'h12345678));
    run_instr(mk16(6'd1, 16'd7), 32'h0, 0);
    run_instr(mk16(6'd2, 16'd5), 32'h0, 0);
    run_instr(mk(OP_SUB, 6'd4, 6'd1, 6'd2), 32'h0, 0);
    chk("reg4", 64'(rf[4]), 64'(2));
    run_instr(mk(OP_CPDR, 6'd0, 6'd1, 6'd0), 32'h0, 4);
    run_instr(mk(8'hFF, 6'd8, 6'd1, 6'd2), 32'h0, 0);
    run_instr(mk(OP_CP, 6'd6, 6'd1, 6'd0), 32'h0, 0);
    chk("reg6", 64'(rf[6]), 64'(7));
    chk("illegal_sticky", 64'(bus.illegal_op), 64'(1));
    run_instr(mk(OP_ADD, 6'd0, 6'd1, 6'd2), 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      i0 = {ops[$urandom_range(0, 11)], 24'($urandom)};
      run_instr(i0, $urandom, int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 64; i++) chk("final_rf", 64'(rf[i]), 64'(mdl[i]));

    // asynchronous reset in the middle of an ALU op
    bus.instr_valid = 1'b1;
    bus.instr0 = mk(OP_ADD, 6'd9, 6'd1, 6'd2);
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("exec_alu_op", 64'(bus.alu_op), 64'(4));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_alu_op", 64'(bus.alu_op), 64'(0));
    chk("arst_alu_d0", 64'(bus.alu_d0), 64'(0));
    chk("arst_ready", 64'(bus.instr_ready), 64'(1));
    chk("arst_illegal", 64'(bus.illegal_op), 64'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("arst_we", 64'(bus.ireg_we), 64'(0));
    end
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_we", 64'(bus.ireg_we), 64'(0));
    end
    chk("reg9_untouched", 64'(rf[9]), 64'(mdl[9]));
    run_instr(mk(OP_CP, 6'd10, 6'd4, 6'd0), 32'h0, 0);
    chk("post_rst_illegal", 64'(bus.illegal_op), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
